// File: rtl/fa_bist_checker.sv
// fa_bist_checker: self-test response checker for an external gate-level full adder.
// Walks all 8 (a,b,cin) vectors, holds each for SETTLE_CYCLES+1 cycles, samples
// sum/c_out on the last cycle and records mismatches.
// Optional build macro FA_CHK_STOP_ON_FAIL_EN: end the run on the first mismatch.
module fa_bist_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             cin,
   input  logic             sum,
   input  logic             c_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_vec
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES);

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [7:0]       fail_q, fail_d;
   logic             pass_q, pass_d;

   logic exp_sum, exp_cout, sample, mismatch, finish;

   // Reference response for the vector currently on the operand outputs
   assign exp_sum  = idx_q[2] ^ idx_q[1] ^ idx_q[0];
   assign exp_cout = (idx_q[2] & idx_q[1]) | (idx_q[2] & idx_q[0]) | (idx_q[1] & idx_q[0]);
   assign sample   = (state_q == StRun) && (cnt_q == '0);
   assign mismatch = sample && ((sum != exp_sum) || (c_out != exp_cout));
`ifdef FA_CHK_STOP_ON_FAIL_EN
   assign finish   = sample && ((idx_q == 3'd7) || mismatch);
`else
   assign finish   = sample && (idx_q == 3'd7);
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic; DONE always lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start)  state_d = StRun;
         StRun:   if (finish) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy = (state_q == StRun);
      done = (state_q == StDone);
   end

   // Vector index, settle counter and result accumulation
   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      fail_d = fail_q;
      pass_d = pass_q;
      if ((state_q == StIdle) && start) begin
         idx_d  = 3'd0;
         cnt_d  = CntLoad;
         err_d  = '0;
         fail_d = '0;
         pass_d = 1'b0;
      end else if (state_q == StRun) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            if (mismatch) begin
               fail_d[idx_q] = 1'b1;
               if (err_q != '1) err_d = err_q + 1'b1;
            end
            // pass must already be valid in the DONE cycle, so use this edge's updates
            if (finish) begin
               pass_d = (err_d == '0) && (fail_d == '0);
            end else begin
               idx_d = idx_q + 1'b1;
               cnt_d = CntLoad;
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= 3'd0;
         cnt_q  <= '0;
         err_q  <= '0;
         fail_q <= '0;
         pass_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         fail_q <= fail_d;
         pass_q <= pass_d;
      end
   end

   // Operands come straight from the index register, so they hold the last vector in DONE
   assign a         = idx_q[2];
   assign b         = idx_q[1];
   assign cin       = idx_q[0];
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: doc/fa_bist_checker.md
Name: fa_bist_checker

Overview:
- Hardware response end for a gate-level full adder: drives all 8 (a,b,cin) vectors into an external full adder, samples sum/c_out, compares against the expected result, and reports pass/fail.
- Built-in self-test companion to the full-adder block, usable on silicon/FPGA without a simulator stimulus.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling; 0 is legal (1 cycle per vector).
- ERR_W, 4, width of the saturating mismatch counter; minimum 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- a  output  1  adder operand A, registered.
- b  output  1  adder operand B, registered.
- cin  output  1  adder carry-in, registered.
- sum  input  1  adder sum response.
- c_out  input  1  adder carry-out response.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  run result; valid from done, held until next start.
- err_count  output  ERR_W  mismatch count, saturating at 2^ERR_W-1.
- fail_vec  output  8  bit k set if vector k mismatched.

Behaviour:
- Reset (async, immediate): state IDLE; a=b=cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vector index 0, settle counter 0.
- Vector k (0..7): a=k[2], b=k[1], cin=k[0]. Expected sum = a^b^cin; expected c_out = (a&b)|(a&cin)|(b&cin).
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> RUN. At E0: idx=0, outputs take vector 0, busy=1, err_count=0, fail_vec=0, pass=0, settle counter=SETTLE_CYCLES.
- RUN: each vector is visible for SETTLE_CYCLES+1 cycles. The counter decrements each edge. At the edge where it is 0, sum/c_out are sampled and compared.
  - On mismatch: fail_vec[idx]=1 and err_count increments, saturating.
  - If idx<7: idx+1, outputs take the next vector, counter reloads.
  - If idx=7: -> DONE.
- Timing with period P=SETTLE_CYCLES+1: vector k is driven after edge E0+kP and sampled at edge E0+(k+1)P. The last sample is at E0+8P.
- DONE: lasts one cycle. done=1, busy=0, pass=(err_count==0 and fail_vec==0). a/b/cin hold vector 7. Next state is IDLE.
- done is 0 in every state except DONE.
- pass, err_count and fail_vec hold until the next accepted start or reset.
- start in RUN or DONE is ignored (no queueing). start held high restarts from IDLE on the edge after DONE.
- Reset mid-run aborts with no done pulse. All outputs return to reset values.
- sum/c_out are sampled synchronously. The external adder path must settle within P cycles; no synchronizers are inside the block.

Optional Feature:
- Macro FA_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatching sample ends the run. The state goes to DONE on that edge, no further vectors are driven, err_count=1, fail_vec has exactly one bit set, and a/b/cin hold the failing vector.
- Undefined: all 8 vectors always run; behaviour as above.

Test Plan:
1. Correct full-adder model, SETTLE_CYCLES=2, one-cycle start at E0 -> a/b/cin step 000..111 at E0,E0+3,...,E0+21; busy high E0..E0+24; done pulse in the cycle after E0+24; pass=1, err_count=0, fail_vec=8'h00.
2. c_out stuck-at-0 -> vectors 3,5,6,7 fail; fail_vec=8'hE8, err_count=4, pass=0.
3. sum inverted, ERR_W=4 -> fail_vec=8'hFF, err_count=8. Same fault with ERR_W=2 -> err_count saturates at 3, fail_vec=8'hFF.
4. SETTLE_CYCLES=0, correct adder -> a new vector every cycle; done in the cycle after E0+8; a start pulse at E0+4 is ignored (no restart, counts unchanged).
5. rst asserted asynchronously while vector 4 is driven -> a/b/cin/busy/err_count/fail_vec go to 0 without waiting for clk; no done. A following start gives a full clean run with pass=1.
6. FA_CHK_STOP_ON_FAIL_EN defined, c_out stuck-at-0, SETTLE_CYCLES=2 -> run stops at sample edge E0+12 (vector 3); done in the next cycle; fail_vec=8'h08, err_count=1, pass=0, a/b/cin=011.
